draw_sprite: RTL and testbench

Parametrised sprite renderer: the next generation of the single-purpose object drawers. It overlays one W×H sprite from an external image ROM onto the VGA stream at a frame-latched position. It adds integer power-of-two scaling, horizontal mirroring, multi-frame animation, a colour-key transparency parameter, a configurable ROM read latency and a per-pixel hit flag for collision logic. It sits in the vga_if draw chain between background/object stages, with the ROM outside the block.

---
 rtl/draw_sprite_if.sv | 22 ++
 rtl/draw_sprite.sv | 171 +++++++++++++++++
 tb/tb_draw_sprite.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_sprite_if.sv
// Stream and position bundles shared by the draw chain stages.
// vga_if carries one pixel per clock; pos_if carries an object's top-left corner.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

interface pos_if;
   logic [10:0] x;
   logic [10:0] y;

   modport in  (input  x, y);
   modport out (output x, y);
endinterface

// File: rtl/draw_sprite.sv
// Overlays one scaled, optionally mirrored, animated sprite from an external ROM
// onto the VGA stream; position/enable/flip are latched on each vblnk rise.
module draw_sprite #(
   parameter int          SPR_W     = 32,
   parameter int          SPR_H     = 32,
   parameter int          SCALE_SH  = 0,
   parameter int          FRAMES    = 1,
   parameter int          FRAME_DIV = 8,
   parameter int          ROM_LAT   = 1,
   parameter int          ADDR_W    = 20,
   parameter logic [11:0] KEY       = 12'hfff
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flip,
   input  logic              anim,
   pos_if.in                 pin,
   vga_if.in                 in,
   input  logic [11:0]       data,
   output logic [ADDR_W-1:0] address,
   vga_if.out                out,
   output logic              hit
);

   localparam int FR_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int SPAN_X = SPR_W << SCALE_SH;
   localparam int SPAN_Y = SPR_H << SCALE_SH;

   typedef struct packed {
      logic        win;
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [11:0] rgb;
   } pix_t;

   logic              vblnk_prev;
   logic              vblnk_rise;
   logic [10:0]       lx;
   logic [10:0]       ly;
   logic              len;
   logic              lflip;
   logic [FR_W-1:0]   frame;
   logic [DIV_W-1:0]  div;

   logic [11:0]       hc12;
   logic [11:0]       vc12;
   logic [11:0]       lx12;
   logic [11:0]       ly12;
   logic [11:0]       du;
   logic [11:0]       dv;
   logic [11:0]       u;
   logic [11:0]       v;
   logic [11:0]       ue;
   logic              win;
   logic [ADDR_W-1:0] address_nxt;
   logic              opaque;

   pix_t              pipe_p [ROM_LAT+1];

   assign vblnk_rise = in.vblnk & ~vblnk_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_prev <= 1'b0;
         lx         <= '0;
         ly         <= '0;
         len        <= 1'b0;
         lflip      <= 1'b0;
      end else begin
         vblnk_prev <= in.vblnk;
         if (vblnk_rise) begin
            lx    <= pin.x;
            ly    <= pin.y;
            len   <= en;
            lflip <= flip;
         end
      end
   end

   // Animation advances once per FRAME_DIV video frames while anim is held high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame <= '0;
         div   <= '0;
      end else if (vblnk_rise && anim) begin
         if (div == DIV_W'(FRAME_DIV - 1)) begin
            div   <= '0;
            frame <= (frame == FR_W'(FRAMES - 1)) ? '0 : frame + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // Window test is done one bit wider than the counters so the right/bottom
   // edges clip instead of wrapping back to column/row 0.
   always_comb begin
      hc12 = {1'b0, in.hcount};
      vc12 = {1'b0, in.vcount};
      lx12 = {1'b0, lx};
      ly12 = {1'b0, ly};
      win  = (hc12 >= lx12) && (hc12 < lx12 + 12'(SPAN_X)) &&
             (vc12 >= ly12) && (vc12 < ly12 + 12'(SPAN_Y));
      du   = hc12 - lx12;
      dv   = vc12 - ly12;
      u    = du >> SCALE_SH;
      v    = dv >> SCALE_SH;
      ue   = lflip ? (12'(SPR_W - 1) - u) : u;
      address_nxt = '0;
      if (win) begin
         address_nxt = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                     + ADDR_W'(v) * ADDR_W'(SPR_W)
                     + ADDR_W'(ue);
      end
   end

   // Stage 0: ROM address goes out; window flag and stream fields enter the delay line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address <= '0;
         for (int k = 0; k <= ROM_LAT; k++) begin
            pipe_p[k] <= '0;
         end
      end else begin
         address   <= address_nxt;
         pipe_p[0] <= '{win:    win,
                        vcount: in.vcount,
                        vsync:  in.vsync,
                        vblnk:  in.vblnk,
                        hcount: in.hcount,
                        hsync:  in.hsync,
                        hblnk:  in.hblnk,
                        rgb:    in.rgb};
         for (int k = 1; k <= ROM_LAT; k++) begin
            pipe_p[k] <= pipe_p[k-1];
         end
      end
   end

   assign opaque = pipe_p[ROM_LAT].win & len & (data != KEY);

   // Output stage: ROM data for this pixel is valid at this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out.vcount <= '0;
         out.vsync  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.hcount <= '0;
         out.hsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.rgb    <= '0;
         hit        <= 1'b0;
      end else begin
         out.vcount <= pipe_p[ROM_LAT].vcount;
         out.vsync  <= pipe_p[ROM_LAT].vsync;
         out.vblnk  <= pipe_p[ROM_LAT].vblnk;
         out.hcount <= pipe_p[ROM_LAT].hcount;
         out.hsync  <= pipe_p[ROM_LAT].hsync;
         out.hblnk  <= pipe_p[ROM_LAT].hblnk;
         out.rgb    <= opaque ? data : pipe_p[ROM_LAT].rgb;
         hit        <= opaque;
      end
   end

endmodule

// File: tb/tb_draw_sprite.sv
// Randomized scoreboard bench for draw_sprite: a pixel-level model predicts each
// output pixel and ROM address; a monitor pops and compares as the DUT produces them.
module tb_draw_sprite;
   localparam int          SPR_W     = 4;
   localparam int          SPR_H     = 4;
   localparam int          SH        = 1;
   localparam int          FRAMES    = 3;
   localparam int          FRAME_DIV = 2;
   localparam int          ROM_LAT   = 2;
   localparam int          ADDR_W    = 8;
   localparam logic [11:0] KEY       = 12'hfff;
   localparam int          LAT       = ROM_LAT + 2;

   typedef struct {
      int          due;
      logic [25:0] ctl;
      logic [11:0] rgb;
      logic        hit;
   } exp_t;

   typedef struct {
      int due;
      int addr;
   } aexp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              flip = 1'b0;
   logic              anim = 1'b0;
   logic [11:0]       data;
   logic [ADDR_W-1:0] address;
   logic              hit;

   vga_if vin ();
   vga_if vout ();
   pos_if pos ();

   draw_sprite #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_SH(SH), .FRAMES(FRAMES),
      .FRAME_DIV(FRAME_DIV), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W), .KEY(KEY)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .flip(flip), .anim(anim),
      .pin(pos), .in(vin), .data(data), .address(address), .out(vout), .hit(hit)
   );

   always #5 clk = ~clk;

   logic [11:0] rom [256];
   logic [11:0] rp  [ROM_LAT];

   always @(posedge clk) begin
      rp[0] <= rom[address];
      for (int k = 1; k < ROM_LAT; k++) rp[k] <= rp[k-1];
   end
   assign data = rp[ROM_LAT-1];

   int    cyc = 0;
   int    n_vec = 0;
   int    n_bad = 0;
   exp_t  q[$];
   aexp_t aq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Model of the latched sprite state.
   int m_lx, m_ly, m_frame, m_div;
   bit m_len, m_lflip, m_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [25:0] ctl_of_out();
      return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (aq.size() > 0 && aq[0].due == cyc) begin
            aexp_t a;
            a = aq.pop_front();
            chk("address", 32'(address), 32'(a.addr));
         end
         if (q.size() > 0) begin
            if (q[0].due == cyc) begin
               exp_t e;
               e = q.pop_front();
               chk("ctl", 32'(ctl_of_out()), 32'(e.ctl));
               chk("rgb", 32'(vout.rgb), 32'(e.rgb));
               chk("hit", 32'(hit), 32'(e.hit));
            end else if (q[0].due > cyc) begin
               chk("fill_ctl", 32'(ctl_of_out()), 32'h0);
               chk("fill_rgb", 32'(vout.rgb), 32'h0);
               chk("fill_hit", 32'(hit), 32'h0);
            end else begin
               chk("late", 32'(q[0].due), 32'(cyc));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic model_reset();
      m_lx = 0; m_ly = 0; m_frame = 0; m_div = 0;
      m_len = 0; m_lflip = 0; m_prev = 0;
   endtask

   task automatic step(input int hc, input int vc, input bit vb);
      exp_t  e;
      aexp_t a;
      bit    w;
      int    u, v, ue, adr;
      logic [11:0] pix;
      @(posedge clk);
      #1;
      rst = 1'b1;
      vin.hcount = 11'(hc);
      vin.vcount = 11'(vc);
      vin.vblnk  = vb;
      vin.vsync  = 1'($urandom);
      vin.hsync  = 1'($urandom);
      vin.hblnk  = 1'($urandom);
      vin.rgb    = 12'($urandom);
      w = (hc >= m_lx) && (hc < m_lx + SPR_W * (1 << SH)) &&
          (vc >= m_ly) && (vc < m_ly + SPR_H * (1 << SH));
      u   = (hc - m_lx) / (1 << SH);
      v   = (vc - m_ly) / (1 << SH);
      ue  = m_lflip ? (SPR_W - 1 - u) : u;
      adr = w ? (m_frame * SPR_W * SPR_H + v * SPR_W + ue) : 0;
      pix = rom[adr];
      e.due = cyc + LAT;
      e.ctl = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk};
      e.hit = w && m_len && (pix != KEY);
      e.rgb = e.hit ? pix : vin.rgb;
      q.push_back(e);
      a.due  = cyc + 1;
      a.addr = adr;
      aq.push_back(a);
      if (vb && !m_prev) begin
         m_lx = int'(pos.x); m_ly = int'(pos.y); m_len = en; m_lflip = flip;
         if (anim) begin
            if (m_div == FRAME_DIV - 1) begin
               m_div   = 0;
               m_frame = (m_frame + 1) % FRAMES;
            end else begin
               m_div++;
            end
         end
      end
      m_prev = vb;
   endtask

   task automatic randomize_ctrl();
      case ($urandom_range(0, 3))
         0:       pos.x = 11'd1022;
         1:       pos.x = 11'($urandom_range(0, 40));
         default: pos.x = 11'($urandom_range(0, 1100));
      endcase
      pos.y = 11'($urandom_range(0, 760));
      en    = ($urandom_range(0, 3) != 0);
      flip  = 1'($urandom);
      anim  = ($urandom_range(0, 4) != 0);
   endtask

   function automatic int near(input int base, input int span);
      int p;
      if ($urandom_range(0, 7) == 0) return $urandom_range(0, 2047);
      p = base + $urandom_range(0, span + 6) - 3;
      if (p < 0) p = 0;
      if (p > 2047) p = 2047;
      return p;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation ran past its time budget");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = ($urandom_range(0, 4) == 0) ? KEY : 12'($urandom_range(0, 12'hffe));
      vin.hcount = '0; vin.vcount = '0; vin.vblnk = 1'b0; vin.vsync = 1'b0;
      vin.hsync = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;
      pos.x = '0; pos.y = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_address", 32'(address), 32'h0);
      chk("rst_ctl", 32'(ctl_of_out()), 32'h0);
      chk("rst_rgb", 32'(vout.rgb), 32'h0);
      chk("rst_hit", 32'(hit), 32'h0);

      for (int f = 0; f < 24; f++) begin
         for (int i = 0; i < ROM_LAT + 3; i++) step(2047, 2047, 1'b0);
         randomize_ctrl();
         for (int i = 0; i < 4; i++) step(2047, 2047, 1'b1);
         for (int i = 0; i < ROM_LAT + 3; i++) step(2047, 2047, 1'b0);
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) randomize_ctrl();
            step(near(m_lx, SPR_W << SH), near(m_ly, SPR_H << SH), 1'b0);
            if (f == 12 && i == 75) begin
               #3;
               rst = 1'b0;
               #1;
               chk("arst_address", 32'(address), 32'h0);
               chk("arst_ctl", 32'(ctl_of_out()), 32'h0);
               chk("arst_rgb", 32'(vout.rgb), 32'h0);
               chk("arst_hit", 32'(hit), 32'h0);
               q.delete();
               aq.delete();
               model_reset();
            end
         end
      end

      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
